s1_sequencer: RTL

Multi-cycle control sequencer for the S1 core. Steps each instruction through FETCH, DECODE, EXEC, MEM and WB phases, arbitrates the single shared memory port between instruction fetch and load/store data access, and issues one-cycle PC, register-file and latch strobes. It holds the current 3-bit opcode, which drives the instruction decode ROM; the ROM's control word steers the datapath muxes. This block decides only when things happen.

---
 rtl/s1_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/s1_sequencer.sv
// S1 core multi-cycle control sequencer: phase stepping,
// shared memory port arbitration and one-cycle datapath strobes.
module s1_sequencer #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       fetch_opcode,
   input  logic             mem_ack,
   input  logic             branch_taken,
   output logic [2:0]       opcode,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_we,
   output logic             mdr_we,
   output logic             rf_we,
   output logic             pc_inc,
   output logic             pc_load,
   output logic             retire,
   output logic [CNT_W-1:0] retired_cnt,
   output logic             bus_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   localparam logic [2:0] OP_STORE = 3'd3;
   localparam logic [2:0] OP_LOAD  = 3'd4;
   localparam logic [2:0] OP_JAL   = 3'd5;
   localparam logic [2:0] OP_JALR  = 3'd6;
   localparam logic [2:0] OP_CJMP  = 3'd7;

   localparam int WW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WW-1:0] WLAST =
      WW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
   localparam logic WD_EN = (MEM_TIMEOUT != 0);

   state_t        state;
   state_t        state_n;
   logic [WW-1:0] wcnt;
   logic          timeout;
   logic          is_mem;
   logic          is_jmp;

   assign is_mem  = (opcode == OP_STORE) || (opcode == OP_LOAD);
   assign is_jmp  = (opcode == OP_JAL) || (opcode == OP_JALR);
   // A same-cycle ack always beats the watchdog.
   assign timeout = WD_EN && mem_req && !mem_ack && (wcnt == WLAST);

   always_comb begin
      state_n  = state;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      ir_we    = 1'b0;
      mdr_we   = 1'b0;
      rf_we    = 1'b0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      retire   = 1'b0;
      unique case (state)
         S_IDLE: state_n = S_FETCH;
         S_FETCH: begin
            mem_req = 1'b1;
            ir_we   = mem_ack;
            if (mem_ack) state_n = S_DECODE;
         end
         S_DECODE: state_n = S_EXEC;
         S_EXEC: begin
            if (opcode == OP_CJMP) begin
               pc_load = branch_taken;
               pc_inc  = !branch_taken;
               retire  = 1'b1;
               state_n = S_FETCH;
            end else if (is_mem) begin
               state_n = S_MEM;
            end else begin
               state_n = S_WB;
            end
         end
         S_MEM: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = (opcode == OP_STORE);
            if (mem_ack) begin
               if (opcode == OP_STORE) begin
                  pc_inc  = 1'b1;
                  retire  = 1'b1;
                  state_n = S_FETCH;
               end else begin
                  mdr_we  = 1'b1;
                  state_n = S_WB;
               end
            end
         end
         S_WB: begin
            rf_we   = 1'b1;
            retire  = 1'b1;
            pc_load = is_jmp;
            pc_inc  = !is_jmp;
            state_n = S_FETCH;
         end
         S_HALT: state_n = S_HALT;
         default: state_n = S_IDLE;
      endcase
      if (timeout) state_n = S_HALT;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         opcode      <= 3'd0;
         retired_cnt <= '0;
         bus_err     <= 1'b0;
         wcnt        <= '0;
      end else begin
         state <= state_n;
         if (state == S_FETCH && mem_ack) opcode <= fetch_opcode;
         if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
         if (timeout) bus_err <= 1'b1;
         // Idle states hold the count at zero, so each
         // FETCH or MEM visit starts counting from zero.
         if (mem_req && !mem_ack) wcnt <= wcnt + WW'(1);
         else wcnt <= '0;
      end
   end

endmodule
